// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble generator for the 5-stage pipeline with memory-wait watchdog.
// Optional PIPE_CTRL_PERF_EN adds saturating per-row cycle counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 1024,
   parameter int unsigned CNT_W       = 11
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic       d_use_rs,
   input  logic       d_use_rt,
   input  logic       e_wreg,
   input  logic       e_m2reg,
   input  logic [4:0] e_rn,
   input  logic       e_branch_taken,
   input  logic       m_mem_req,
   input  logic       m_mem_ready,
`ifdef PIPE_CTRL_PERF_EN
   output logic [31:0] perf_mem_cycles,
   output logic [31:0] perf_branch_flush,
   output logic [31:0] perf_load_use,
`endif
   output logic       f_stall,
   output logic       d_stall,
   output logic       e_stall,
   output logic       m_stall,
   output logic       w_stall,
   output logic       d_bubble,
   output logic       e_bubble,
   output logic       m_bubble,
   output logic       w_bubble,
   output logic       mem_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic mem_miss;
   logic mem_wait;
   logic load_use;
   logic row_mem;
   logic row_br;
   logic row_lu;

   assign mem_miss = m_mem_req & ~m_mem_ready;
   assign mem_wait = mem_miss | (state_q == S_ERR);

   assign load_use = e_wreg & e_m2reg & (e_rn != 5'd0)
                   & ((d_use_rs & (d_rs == e_rn))
                   |  (d_use_rt & (d_rt == e_rn)));

   // One-hot priority rows: memory wait, then branch flush, then load-use.
   assign row_mem = resetn & mem_wait;
   assign row_br  = resetn & ~mem_wait & e_branch_taken;
   assign row_lu  = resetn & ~mem_wait & ~e_branch_taken & load_use;

   // State and wait-counter register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: count consecutive wait cycles, trap in ERR on timeout.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (mem_miss) begin
               state_d = S_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         S_WAIT: begin
            if (!mem_miss) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Decode the active row into stage stall/bubble controls.
   always_comb begin
      f_stall  = 1'b0;
      d_stall  = 1'b0;
      e_stall  = 1'b0;
      m_stall  = 1'b0;
      d_bubble = 1'b0;
      e_bubble = 1'b0;
      w_bubble = 1'b0;
      unique case (1'b1)
         row_mem: begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_stall  = 1'b1;
            m_stall  = 1'b1;
            w_bubble = 1'b1;
         end
         row_br: begin
            d_bubble = 1'b1;
            e_bubble = 1'b1;
         end
         row_lu: begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign w_stall  = 1'b0;
   assign m_bubble = 1'b0;
   assign mem_err  = (state_q == S_ERR);

`ifdef PIPE_CTRL_PERF_EN
   // Saturating cycle counters, one per priority row.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_mem_cycles   <= '0;
         perf_branch_flush <= '0;
         perf_load_use     <= '0;
      end else begin
         if (row_mem && perf_mem_cycles != '1)
            perf_mem_cycles <= perf_mem_cycles + 32'd1;
         if (row_br && perf_branch_flush != '1)
            perf_branch_flush <= perf_branch_flush + 32'd1;
         if (row_lu && perf_load_use != '1)
            perf_load_use <= perf_load_use + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=8).
// Stimulus queues expected vectors; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic [4:0] d_rs, d_rt, e_rn;
   logic       d_use_rs, d_use_rt, e_wreg, e_m2reg;
   logic       e_branch_taken, m_mem_req, m_mem_ready;
   logic       f_stall, d_stall, e_stall, m_stall, w_stall;
   logic       d_bubble, e_bubble, m_bubble, w_bubble, mem_err;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_mem_cycles, perf_branch_flush, perf_load_use;
`endif

   int tests = 0;
   int fails = 0;

   // {f,d,e,m,w stall, d,e,m,w bubble, mem_err}
   localparam logic [9:0] E_NONE = 10'b00000_0000_0;
   localparam logic [9:0] E_MEM  = 10'b11110_0001_0;
   localparam logic [9:0] E_BR   = 10'b00000_1100_0;
   localparam logic [9:0] E_LU   = 10'b11000_0100_0;
   localparam logic [9:0] E_ERR  = 10'b11110_0001_1;

   logic [9:0] exp_q[$];
   string      name_q[$];

   pipeline_hazard_ctrl #(
      .MEM_TIMEOUT(8),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .d_rs(d_rs),
      .d_rt(d_rt),
      .d_use_rs(d_use_rs),
      .d_use_rt(d_use_rt),
      .e_wreg(e_wreg),
      .e_m2reg(e_m2reg),
      .e_rn(e_rn),
      .e_branch_taken(e_branch_taken),
      .m_mem_req(m_mem_req),
      .m_mem_ready(m_mem_ready),
`ifdef PIPE_CTRL_PERF_EN
      .perf_mem_cycles(perf_mem_cycles),
      .perf_branch_flush(perf_branch_flush),
      .perf_load_use(perf_load_use),
`endif
      .f_stall(f_stall),
      .d_stall(d_stall),
      .e_stall(e_stall),
      .m_stall(m_stall),
      .w_stall(w_stall),
      .d_bubble(d_bubble),
      .e_bubble(e_bubble),
      .m_bubble(m_bubble),
      .w_bubble(w_bubble),
      .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   // Monitor: compare DUT outputs against queued expectations.
   always @(negedge clk) begin
      logic [9:0] got, e;
      string n;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         got = {f_stall, d_stall, e_stall, m_stall, w_stall,
                d_bubble, e_bubble, m_bubble, w_bubble, mem_err};
         tests++;
         if (got !== e) begin
            fails++;
            $display("FAIL %s: got %b expected %b", n, got, e);
         end
      end
   end

   task automatic step(input logic rst,
                       input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic wreg, input logic m2reg,
                       input logic [4:0] rn, input logic br,
                       input logic req, input logic rdy,
                       input logic [9:0] exp, input string name);
      @(posedge clk);
      #1;
      resetn         = rst;
      d_rs           = rs;
      d_use_rs       = urs;
      d_rt           = rt;
      d_use_rt       = urt;
      e_wreg         = wreg;
      e_m2reg        = m2reg;
      e_rn           = rn;
      e_branch_taken = br;
      m_mem_req      = req;
      m_mem_ready    = rdy;
      exp_q.push_back(exp);
      name_q.push_back(name);
   endtask

   task automatic idle(input logic [9:0] exp, input string name);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp, name);
   endtask

   task automatic check32(input string name,
                          input logic [31:0] got,
                          input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 0;
      d_rs = 0; d_rt = 0; e_rn = 0;
      d_use_rs = 0; d_use_rt = 0; e_wreg = 0; e_m2reg = 0;
      e_branch_taken = 0; m_mem_req = 0; m_mem_ready = 0;

      // reset: outputs forced low even with hazards present
      step(0, 5, 1, 0, 0, 1, 1, 5, 1, 1, 0, E_NONE, "rst_hold0");
      step(0, 5, 1, 0, 0, 1, 1, 5, 1, 1, 0, E_NONE, "rst_hold1");
      idle(E_NONE, "rst_release");

      // load-use on rs, then load moved on
      step(1, 5, 1, 0, 0, 1, 1, 5, 0, 0, 0, E_LU, "lu_rs");
      step(1, 5, 1, 0, 0, 0, 0, 9, 0, 0, 0, E_NONE, "lu_done");
      // r0 never hazards
      step(1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, E_NONE, "lu_r0");
      // rt match but not used
      step(1, 1, 1, 7, 0, 1, 1, 7, 0, 0, 0, E_NONE, "lu_rt_unused");
      // ALU result, not a load
      step(1, 7, 1, 0, 0, 1, 0, 7, 0, 0, 0, E_NONE, "lu_not_load");
      // load without register write
      step(1, 7, 1, 0, 0, 0, 1, 7, 0, 0, 0, E_NONE, "lu_no_wreg");

      // 3-cycle memory wait, release on ready cycle
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MEM, "mem_w1");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MEM, "mem_w2");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MEM, "mem_w3");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_NONE, "mem_ready");
      idle(E_NONE, "mem_after");

      // branch beats load-use
      step(1, 5, 1, 0, 0, 1, 1, 5, 1, 0, 0, E_BR, "br_over_lu");

      // branch held through a 2-cycle wait, serviced on ready
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_MEM, "br_mem_w1");
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_MEM, "br_mem_w2");
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, E_BR, "br_mem_rel");
      idle(E_NONE, "br_after");

`ifdef PIPE_CTRL_PERF_EN
      @(negedge clk);
      #1;
      check32("perf_mem_cycles", perf_mem_cycles, 32'd5);
      check32("perf_branch_flush", perf_branch_flush, 32'd2);
      check32("perf_load_use", perf_load_use, 32'd1);
`endif

      // request dropped mid-wait clears the counter
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MEM, "drop_w1");
      idle(E_NONE, "drop_idle");

      // timeout: 8 wait cycles, then ERR forever
      for (int i = 0; i < 8; i++)
         step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MEM, $sformatf("to_w%0d", i + 1));
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_ERR, "to_err");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_ERR, "to_err_ready");
      idle(E_ERR, "to_err_idle");
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_ERR, "to_err_br");

      // async reset clears ERR
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_NONE, "err_rst");
      idle(E_NONE, "err_rst_release");
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_BR, "post_rst_br");

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
